// File: rtl/jk_drive_ctrl.sv
// ---------------------------------------------------------------------------
// jk_drive_ctrl
//   Drives a bank of WIDTH external JK flip-flops towards a requested target
//   word. Each attempt issues one registered J/K pulse, waits one cycle for
//   the bank's registered q to come back, then compares. Mismatches are
//   re-driven up to MAX_RETRY times before completing with err=1.
//
// Parameters
//   WIDTH      number of external JK flip-flops
//   MAX_RETRY  re-drive attempts after the first failed check (fits retry_cnt)
//   USE_TOGGLE 1: differing bits driven with J=K=1; 0: set/reset pairs
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   target word offered
//   in_target  desired flip-flop state
//   in_ready   controller accepts a target this cycle (IDLE only)
//   q_fb       registered q outputs fed back from the flip-flop bank
//   j, k       registered J/K drives, non-zero only in the DRIVE cycle
//   busy       command in progress
//   done       one-cycle completion pulse
//   err        qualifies done: target not reached within the retry budget
//   retry_cnt  re-drives used by the current or last command
// ---------------------------------------------------------------------------
module jk_drive_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 3,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_target,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       retry_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] MAX_RC = 2'(MAX_RETRY);

    state_t           state;
    logic [WIDTH-1:0] target;

    // J/K pair that moves the present q onto t; bits already equal stay at 0/0.
    function automatic logic [2*WIDTH-1:0] jk_for(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
        if (USE_TOGGLE != 0)
            return {diff, diff};
        else
            return {diff & t, diff & ~t};
    endfunction

    assign busy = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would let later statements see
    // already-updated state and break the one-cycle DRIVE/CHECK timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= 2'd0;
            // in_ready comes up on the first edge after reset releases.
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        target    <= in_target;
                        retry_cnt <= 2'd0;
                        {j, k}    <= jk_for(q_fb, in_target);
                        in_ready  <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Single-cycle pulse; the bank sees it on this edge.
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (retry_cnt < MAX_RC) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        {j, k}    <= jk_for(q_fb, target);
                        state     <= DRIVE;
                    end else begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
